// File: rtl/tdm_slot_sequencer.sv
// ---------------------------------------------------------------------------
// tdm_slot_sequencer
//
// Frame aligner that feeds the 1-to-16 channel demultiplexer in the receive
// path. It hunts the serial TDM stream for the sync word and locks onto the
// frame. While framed, it forwards each payload bit together with the 4-bit
// select of the slot that bit belongs to. It checks the sync word at the end
// of every frame and drops back to hunting after MISS_LIMIT consecutive misses.
//
// Frame layout: 16 slots of BITS_PER_SLOT payload bits, then SYNC_W sync bits.
//
// Parameters:
//   SYNC_W         sync word length in bits (2..16)
//   SYNC_WORD      expected sync pattern, MSB received first
//   BITS_PER_SLOT  payload bits per slot (2..64)
//   MISS_LIMIT     consecutive bad sync words that drop lock (1..7)
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   bit_in       in   serial received bit
//   bit_valid    in   bit_in qualifier; only qualified cycles advance state
//   slot_enable  in   [15:0] per-slot output enable (TDM_SLOT_MASK_EN only)
//   data_out     out  payload bit to the demux (0 whenever data_valid=0)
//   select_out   out  [3:0] slot/channel index to the demux select
//   data_valid   out  data_out/select_out carry a payload bit
//   locked       out  frame lock indicator
//   frame_start  out  pulse with the first payload bit of slot 0
//   sync_err     out  pulse when a sync check fails
//
// Build option:
//   TDM_SLOT_MASK_EN  adds slot_enable; masked slots keep counting and still
//                     pulse frame_start, but produce data_valid=0, data_out=0.
// ---------------------------------------------------------------------------
module tdm_slot_sequencer #(
    parameter int                SYNC_W        = 8,
    parameter logic [SYNC_W-1:0] SYNC_WORD     = 8'hA5,
    parameter int                BITS_PER_SLOT = 8,
    parameter int                MISS_LIMIT    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bit_in,
    input  logic        bit_valid,
`ifdef TDM_SLOT_MASK_EN
    input  logic [15:0] slot_enable,
`endif
    output logic        data_out,
    output logic [3:0]  select_out,
    output logic        data_valid,
    output logic        locked,
    output logic        frame_start,
    output logic        sync_err
);

    localparam int BIT_W = (BITS_PER_SLOT > 1) ? $clog2(BITS_PER_SLOT) : 1;
    localparam int CHK_W = $clog2(SYNC_W);

    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(BITS_PER_SLOT - 1);
    localparam logic [CHK_W-1:0] CHK_LAST = CHK_W'(SYNC_W - 1);
    localparam logic [2:0]       MISS_MAX = 3'(MISS_LIMIT);

    typedef enum logic [1:0] {
        HUNT,
        FRAME,
        CHECK
    } state_t;

    state_t            state;
    logic [SYNC_W-1:0] shift_reg;
    logic [BIT_W-1:0]  bit_cnt;
    logic [3:0]        slot_cnt;
    logic [CHK_W-1:0]  chk_cnt;
    logic [2:0]        miss_cnt;

    logic [SYNC_W-1:0] shift_next;
    logic [2:0]        miss_next;
    logic              slot_on;

    // The sync comparison includes the bit arriving this cycle, so a match is
    // acted on in the same qualified cycle as its last bit.
    assign shift_next = {shift_reg[SYNC_W-2:0], bit_in};
    assign miss_next  = miss_cnt + 3'd1;

    // Per-slot output gating; it does not affect counting or sync checking.
`ifdef TDM_SLOT_MASK_EN
    assign slot_on = slot_enable[slot_cnt];
`else
    assign slot_on = 1'b1;
`endif

    // Single sequencer: HUNT searches for the sync word bit by bit. FRAME
    // walks the 16 slots and emits registered payload bits. CHECK gathers the
    // next sync word and decides whether to keep, flywheel or drop the frame.
    // The pulse outputs default low each cycle, so idle (bit_valid=0) cycles
    // emit nothing and leave all counters untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= HUNT;
            shift_reg   <= '0;
            bit_cnt     <= '0;
            slot_cnt    <= 4'd0;
            chk_cnt     <= '0;
            miss_cnt    <= 3'd0;
            data_out    <= 1'b0;
            select_out  <= 4'd0;
            data_valid  <= 1'b0;
            locked      <= 1'b0;
            frame_start <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            data_out    <= 1'b0;
            data_valid  <= 1'b0;
            frame_start <= 1'b0;
            sync_err    <= 1'b0;
            if (bit_valid) begin
                case (state)
                    HUNT: begin
                        shift_reg <= shift_next;
                        if (shift_next == SYNC_WORD) begin
                            state    <= FRAME;
                            slot_cnt <= 4'd0;
                            bit_cnt  <= '0;
                        end
                    end
                    FRAME: begin
                        data_valid  <= slot_on;
                        data_out    <= bit_in & slot_on;
                        select_out  <= slot_cnt;
                        frame_start <= (slot_cnt == 4'd0) && (bit_cnt == '0);
                        if (bit_cnt == BIT_LAST) begin
                            // Slot counter wraps 15 -> 0, which is where
                            // the next frame starts after the sync check.
                            bit_cnt  <= '0;
                            slot_cnt <= slot_cnt + 4'd1;
                            if (slot_cnt == 4'd15) begin
                                state   <= CHECK;
                                chk_cnt <= '0;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        end
                    end
                    CHECK: begin
                        shift_reg <= shift_next;
                        chk_cnt   <= chk_cnt + CHK_W'(1);
                        if (chk_cnt == CHK_LAST) begin
                            if (shift_next == SYNC_WORD) begin
                                miss_cnt <= 3'd0;
                                locked   <= 1'b1;
                                state    <= FRAME;
                            end else begin
                                sync_err <= 1'b1;
                                if (miss_next == MISS_MAX) begin
                                    locked   <= 1'b0;
                                    miss_cnt <= 3'd0;
                                    state    <= HUNT;
                                end else begin
                                    // Flywheel: assume the frame timing
                                    // still holds.
                                    miss_cnt <= miss_next;
                                    state    <= FRAME;
                                end
                            end
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tdm_slot_sequencer.sv
// ---------------------------------------------------------------------------
// tb_tdm_slot_sequencer
//
// Bench for tdm_slot_sequencer at its default parameters. It drives bits on the
// falling edge and samples outputs on the following falling edge. Expected
// outputs come from a frame-position model: it tracks one integer position
// within the current frame and derives the slot by division.
// ---------------------------------------------------------------------------
module tb_tdm_slot_sequencer;

    localparam int         SW         = 8;
    localparam logic [7:0] SYNC       = 8'hA5;
    localparam int         BPS        = 8;
    localparam int         MISS_LIM   = 2;
    localparam int         FRAME_BITS = 16 * BPS;

    logic        clk;
    logic        rst_n;
    logic        bit_in;
    logic        bit_valid;
    logic        data_out;
    logic [3:0]  select_out;
    logic        data_valid;
    logic        locked;
    logic        frame_start;
    logic        sync_err;
    logic [15:0] slot_en;

    int tests_run;
    int fail_count;

    // Reference model state: mode 0=hunting, 1=payload, 2=sync check.
    int          m_mode;
    int          m_pos;
    int          m_miss;
    logic [SW-1:0] m_win;
    logic        m_locked;

    // Expected outputs after the next active edge.
    logic        e_dv;
    logic        e_do;
    logic [3:0]  e_sel;
    logic        e_fs;
    logic        e_err;

    tdm_slot_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bit_in      (bit_in),
        .bit_valid   (bit_valid),
`ifdef TDM_SLOT_MASK_EN
        .slot_enable (slot_en),
`endif
        .data_out    (data_out),
        .select_out  (select_out),
        .data_valid  (data_valid),
        .locked      (locked),
        .frame_start (frame_start),
        .sync_err    (sync_err)
    );

    always #5 clk = ~clk;

    // Single comparison point for all checks.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time, observed, expected);
        end
    endtask

    task automatic modelReset();
        m_mode   = 0;
        m_pos    = 0;
        m_miss   = 0;
        m_win    = '0;
        m_locked = 1'b0;
        e_dv     = 1'b0;
        e_do     = 1'b0;
        e_sel    = 4'd0;
        e_fs     = 1'b0;
        e_err    = 1'b0;
    endtask

    // Apply one cycle of input to the model.
    task automatic modelStep(input logic b, input logic v);
        int slot;
        logic en;
        e_dv  = 1'b0;
        e_do  = 1'b0;
        e_fs  = 1'b0;
        e_err = 1'b0;
        if (v) begin
            case (m_mode)
                0: begin
                    m_win = {m_win[SW-2:0], b};
                    if (m_win == SYNC) begin
                        m_mode = 1;
                        m_pos  = 0;
                    end
                end
                1: begin
                    slot = m_pos / BPS;
`ifdef TDM_SLOT_MASK_EN
                    en = slot_en[slot];
`else
                    en = 1'b1;
`endif
                    e_sel = 4'(slot);
                    e_dv  = en;
                    e_do  = b & en;
                    e_fs  = (m_pos == 0);
                    m_pos++;
                    if (m_pos == FRAME_BITS) begin
                        m_mode = 2;
                        m_pos  = 0;
                    end
                end
                default: begin
                    m_win = {m_win[SW-2:0], b};
                    m_pos++;
                    if (m_pos == SW) begin
                        m_pos = 0;
                        if (m_win == SYNC) begin
                            m_miss   = 0;
                            m_locked = 1'b1;
                            m_mode   = 1;
                        end else begin
                            e_err = 1'b1;
                            m_miss++;
                            if (m_miss == MISS_LIM) begin
                                m_miss   = 0;
                                m_locked = 1'b0;
                                m_mode   = 0;
                            end else begin
                                m_mode = 1;
                            end
                        end
                    end
                end
            endcase
        end
    endtask

    task automatic compareAll();
        checkOutput("data_valid", 32'(data_valid), 32'(e_dv));
        checkOutput("data_out", 32'(data_out), 32'(e_do));
        checkOutput("frame_start", 32'(frame_start), 32'(e_fs));
        checkOutput("sync_err", 32'(sync_err), 32'(e_err));
        checkOutput("locked", 32'(locked), 32'(m_locked));
        if (e_dv)
            checkOutput("select_out", 32'(select_out), 32'(e_sel));
    endtask

    // One clock: check the previous cycle's result, then drive the next input.
    task automatic applyStimulus(input logic b, input logic v);
        @(negedge clk);
        compareAll();
        bit_in    = b;
        bit_valid = v;
        modelStep(b, v);
    endtask

    // One qualified bit, optionally preceded by a few idle cycles.
    task automatic sendBit(input logic b, input int gap_pct);
        for (int i = 0; i < 4; i++) begin
            if (int'($urandom_range(0, 99)) >= gap_pct) break;
            applyStimulus(1'($urandom), 1'b0);
        end
        applyStimulus(b, 1'b1);
    endtask

    task automatic sendWord(input logic [7:0] w, input int gap_pct);
        for (int i = 7; i >= 0; i--) sendBit(w[i], gap_pct);
    endtask

    // Random bits that never complete a sync word while hunting.
    task automatic sendNoise(input int n);
        logic b;
        logic [SW-1:0] w;
        for (int i = 0; i < n; i++) begin
            b = 1'($urandom);
            w = {m_win[SW-2:0], b};
            if (m_mode == 0 && w == SYNC) b = ~b;
            sendBit(b, 0);
        end
    endtask

    // Payload where slot k carries the value k, MSB first.
    task automatic sendSlotFrame(input int gap_pct);
        logic [7:0] v;
        for (int k = 0; k < 16; k++) begin
            v = 8'(k);
            for (int i = BPS - 1; i >= 0; i--) sendBit(v[i], gap_pct);
        end
    endtask

    task automatic sendRandBits(input int n, input int gap_pct);
        for (int i = 0; i < n; i++) sendBit(1'($urandom), gap_pct);
    endtask

    // Asynchronous reset in the middle of a clock phase.
    task automatic midReset();
        #2 rst_n = 1'b0;
        bit_valid = 1'b0;
        #1 modelReset();
        compareAll();
        checkOutput("rst_select", 32'(select_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] sw;
        tests_run  = 0;
        fail_count = 0;
        clk        = 1'b0;
        rst_n      = 1'b0;
        bit_in     = 1'b0;
        bit_valid  = 1'b0;
        slot_en    = 16'h00FF;
        modelReset();

        // Reset values, then a long idle stretch.
        #12;
        compareAll();
        checkOutput("rst_select", 32'(select_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) applyStimulus(1'($urandom), 1'b0);

        // Hunt, first frame, lock on the second sync word.
        sendNoise(20);
        sendWord(SYNC, 0);
        sendSlotFrame(0);
        sendWord(SYNC, 0);

        // One miss keeps lock; two consecutive misses drop it.
        sendRandBits(FRAME_BITS, 0);
        sendWord(8'hA4, 0);
        sendRandBits(FRAME_BITS, 0);
        sendWord(SYNC, 0);
        sendRandBits(FRAME_BITS, 0);
        sendWord(8'hA4, 0);
        sendRandBits(FRAME_BITS, 0);
        sendWord(8'hA4, 0);
        sendNoise(30);

        // Re-acquire with bit_valid gaps throughout.
        sendWord(SYNC, 40);
        sendSlotFrame(40);
        sendWord(SYNC, 40);
        sendSlotFrame(40);
        sendWord(SYNC, 40);

        // Reset at slot 7 bit 3 of a frame, then require a new hunt.
        sendRandBits(7 * BPS + 3, 0);
        midReset();
        sendNoise(20);
        sendWord(SYNC, 0);
        sendSlotFrame(0);
        sendWord(SYNC, 0);

        // Random frames with random gaps, occasional corrupted sync words.
        for (int f = 0; f < 4; f++) begin
`ifdef TDM_SLOT_MASK_EN
            slot_en = 16'($urandom);
`endif
            sendRandBits(FRAME_BITS, int'($urandom_range(0, 50)));
            sw = SYNC;
            if ($urandom_range(0, 99) < 30) sw = sw ^ 8'(1 << $urandom_range(0, 7));
            sendWord(sw, int'($urandom_range(0, 50)));
        end

        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule
